// File: rtl/adder_seq_ctrl_if.sv
// adder_seq_ctrl_if
//   Handshake bundle between a val/rdy operand producer, the sequenced adder
//   controller and a val/rdy result consumer.
//   Parameter:
//     W         total operand/result width (nbits*nchunks of the controller)
//   Signals:
//     in_val    producer -> controller  operands valid
//     in_rdy    controller -> producer  controller can accept operands
//     in_a/in_b producer -> controller  W-bit operands
//     in_cin    producer -> controller  carry-in to the lowest chunk
//     out_val   controller -> consumer  result valid
//     out_rdy   consumer -> controller  consumer accepts result
//     out_sum   controller -> consumer  W-bit sum
//     out_cout  controller -> consumer  carry-out of the top chunk
//   Modports: master = producer/consumer side, slave = controller side.
interface adder_seq_ctrl_if #(
  parameter int W = 32
);
  logic         in_val;
  logic         in_rdy;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_val;
  logic         out_rdy;
  logic [W-1:0] out_sum;
  logic         out_cout;

  modport master (
    output in_val, in_a, in_b, in_cin, out_rdy,
    input  in_rdy, out_val, out_sum, out_cout
  );

  modport slave (
    input  in_val, in_a, in_b, in_cin, out_rdy,
    output in_rdy, out_val, out_sum, out_cout
  );
endinterface

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl
//   Performs one W = nbits*nchunks bit addition by stepping a single
//   nbits-wide adder slice over nchunks cycles, carrying between chunks.
//   One transaction in flight; draining a result and accepting new operands
//   may happen on the same edge.
//   Parameters:
//     nbits    width of the adder slice (>= 1)
//     nchunks  number of slices per transaction (>= 1)
//   Ports:
//     clk      clock, all state updates on the rising edge
//     reset    asynchronous active-low reset
//     bus      adder_seq_ctrl_if slave modport (operand and result handshakes)
module adder_seq_ctrl #(
  parameter int nbits   = 8,
  parameter int nchunks = 4
) (
  input logic             clk,
  input logic             reset,
  adder_seq_ctrl_if.slave bus
);

  localparam int W    = nbits * nchunks;
  localparam int IDXW = $clog2(nchunks > 2 ? nchunks : 2);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(nchunks - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [IDXW-1:0]   idx;
  logic [W-1:0]      a_reg;
  logic [W-1:0]      b_reg;
  logic [W-1:0]      sum_reg;
  logic              carry;
  logic              cout_reg;

  logic              accept;
  int                base;
  logic [nbits-1:0]  a_slice;
  logic [nbits-1:0]  b_slice;
  logic [nbits-1:0]  slice_sum;
  logic              slice_cout;

  // in_rdy also covers DONE with out_rdy high so a drain and a new accept
  // can share one edge, giving back-to-back transactions with no bubble.
  assign bus.in_rdy   = (state == IDLE) || ((state == DONE) && bus.out_rdy);
  assign bus.out_val  = (state == DONE);
  assign bus.out_sum  = sum_reg;
  assign bus.out_cout = cout_reg;
  assign accept       = bus.in_val && bus.in_rdy;

  // The shared slice: the only carry chain in the design, fed through the
  // idx-selected chunk mux.
  // NOTE: every signal here is assigned on every pass, so no latch can form.
  always_comb begin
    base                    = int'(idx) * nbits;
    a_slice                 = a_reg[base +: nbits];
    b_slice                 = b_reg[base +: nbits];
    {slice_cout, slice_sum} = {1'b0, a_slice} + {1'b0, b_slice} + {{nbits{1'b0}}, carry};
  end

  // NOTE: registers use non-blocking assignments so each one samples the
  // values present before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      carry    <= 1'b0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            // sum_reg/cout_reg keep the old result until overwritten in CALC.
            a_reg <= bus.in_a;
            b_reg <= bus.in_b;
            carry <= bus.in_cin;
            idx   <= '0;
            state <= CALC;
          end else if (state == DONE && bus.out_rdy) begin
            state <= IDLE;
          end
        end
        CALC: begin
          sum_reg[base +: nbits] <= slice_sum;
          carry                  <= slice_cout;
          if (idx == LAST_IDX) begin
            cout_reg <= slice_cout;
            idx      <= '0;
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl
//   Directed bench for adder_seq_ctrl: a 32-bit instance (nbits=8, nchunks=4)
//   and a degenerate 8-bit instance (nbits=8, nchunks=1) sharing clk/reset.
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge. Latency is counted in cycles: the accept cycle is cycle 0, the
//   cycle right after the accept edge is cycle 1.
module tb_adder_seq_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   cyc;

  adder_seq_ctrl_if #(.W(32)) bus  ();
  adder_seq_ctrl_if #(.W(8))  bus1 ();

  adder_seq_ctrl #(.nbits(8), .nchunks(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  adder_seq_ctrl #(.nbits(8), .nchunks(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin);
    bus.in_a   = a;
    bus.in_b   = b;
    bus.in_cin = cin;
  endtask

  // Call just after an accept edge. Returns the cycle in which out_val was
  // first seen (bounded) and whether in_rdy was ever high before that.
  task automatic wait_out(output int lat, output logic rdy_seen);
    lat      = 1;
    rdy_seen = 1'b0;
    @(negedge clk);
    while (bus.out_val !== 1'b1 && lat < 20) begin
      rdy_seen = rdy_seen | bus.in_rdy;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
  } vec_t;

  vec_t b2b [3];
  int   lat;
  logic rdy_seen;
  int   stamp [3];
  int   hits;

  initial begin
    n_checks = 0;
    n_errors = 0;
    b2b[0] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0};
    b2b[1] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
    b2b[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};

    reset        = 1'b0;
    bus.in_val   = 1'b0;
    bus.out_rdy  = 1'b1;
    drive(32'h0, 32'h0, 1'b0);
    bus1.in_val  = 1'b0;
    bus1.out_rdy = 1'b1;
    bus1.in_a    = 8'h00;
    bus1.in_b    = 8'h00;
    bus1.in_cin  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_val", bus.out_val, 1'b0);
    check("rst_in_rdy", bus.in_rdy, 1'b1);
    check("rst_out_sum", bus.out_sum, 32'h0);
    check("rst_out_cout", bus.out_cout, 1'b0);
    check("rst_in_rdy_n1", bus1.in_rdy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_in_rdy", bus.in_rdy, 1'b1);
    check("post_rst_out_val", bus.out_val, 1'b0);

    // Carry ripple through every chunk
    drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    bus.in_val = 1'b1;
    @(posedge clk);
    #1 bus.in_val = 1'b0;
    wait_out(lat, rdy_seen);
    check("ripple_lat", lat, 5);
    check("ripple_calc_rdy", rdy_seen, 1'b0);
    check("ripple_sum", bus.out_sum, 32'h0000_0000);
    check("ripple_cout", bus.out_cout, 1'b1);

    // Inter-chunk carry plus carry-in
    @(negedge clk);
    check("idle_out_val", bus.out_val, 1'b0);
    drive(32'h00FF_00FF, 32'h0001_0001, 1'b1);
    bus.in_val = 1'b1;
    @(posedge clk);
    #1 bus.in_val = 1'b0;
    wait_out(lat, rdy_seen);
    check("cin_lat", lat, 5);
    check("cin_sum", bus.out_sum, 32'h0100_0101);
    check("cin_cout", bus.out_cout, 1'b0);

    // Back-pressure with in_val held high
    @(negedge clk);
    bus.out_rdy = 1'b0;
    drive(32'h1234_5678, 32'h1111_1111, 1'b0);
    bus.in_val = 1'b1;
    @(posedge clk);
    #1 drive(32'h0000_000A, 32'h0000_0005, 1'b0);
    wait_out(lat, rdy_seen);
    check("bp_lat", lat, 5);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      check($sformatf("bp_hold_val_%0d", i), bus.out_val, 1'b1);
      check($sformatf("bp_hold_sum_%0d", i), bus.out_sum, 32'h2345_6789);
      check($sformatf("bp_hold_cout_%0d", i), bus.out_cout, 1'b0);
      check($sformatf("bp_hold_rdy_%0d", i), bus.in_rdy, 1'b0);
    end
    @(posedge clk);
    @(negedge clk);
    bus.out_rdy = 1'b1;
    #1 check("bp_release_rdy", bus.in_rdy, 1'b1);
    @(posedge clk);
    #1 bus.in_val = 1'b0;
    wait_out(lat, rdy_seen);
    check("bp_second_lat", lat, 5);
    check("bp_second_sum", bus.out_sum, 32'h0000_000F);
    check("bp_second_cout", bus.out_cout, 1'b0);

    // Back-to-back with in_val high continuously
    @(negedge clk);
    drive(b2b[0].a, b2b[0].b, b2b[0].cin);
    bus.in_val = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (k < 2) drive(b2b[k+1].a, b2b[k+1].b, b2b[k+1].cin);
      else bus.in_val = 1'b0;
      wait_out(lat, rdy_seen);
      stamp[k] = cyc;
      check($sformatf("b2b_lat_%0d", k), lat, 5);
      check($sformatf("b2b_sum_%0d", k), bus.out_sum, b2b[k].sum);
      check($sformatf("b2b_cout_%0d", k), bus.out_cout, b2b[k].cout);
    end
    check("b2b_gap_01", stamp[1] - stamp[0], 5);
    check("b2b_gap_12", stamp[2] - stamp[1], 5);

    // Reset two cycles into CALC
    @(negedge clk);
    drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    bus.in_val = 1'b1;
    @(posedge clk);
    #1 bus.in_val = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_out_val", bus.out_val, 1'b0);
    check("rst_mid_in_rdy", bus.in_rdy, 1'b1);
    check("rst_mid_out_sum", bus.out_sum, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_val === 1'b1) hits++;
    end
    check("rst_mid_no_stale", hits, 0);
    drive(32'd5, 32'd7, 1'b0);
    bus.in_val = 1'b1;
    @(posedge clk);
    #1 bus.in_val = 1'b0;
    wait_out(lat, rdy_seen);
    check("rst_next_lat", lat, 5);
    check("rst_next_sum", bus.out_sum, 32'd12);
    check("rst_next_cout", bus.out_cout, 1'b0);

    // Degenerate single-chunk instance
    @(negedge clk);
    bus1.in_a   = 8'hFF;
    bus1.in_b   = 8'h01;
    bus1.in_cin = 1'b0;
    bus1.in_val = 1'b1;
    @(posedge clk);
    #1 bus1.in_val = 1'b0;
    lat = 1;
    @(negedge clk);
    while (bus1.out_val !== 1'b1 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("n1_lat", lat, 2);
    check("n1_sum", bus1.out_sum, 8'h00);
    check("n1_cout", bus1.out_cout, 1'b1);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
